// File: rtl/gmsk_rx.sv
`default_nettype none
// ============================================================================
// Module   : gmsk_rx
// Brief    : One-symbol differential GMSK demodulator with a sign slicer.
// Revision : 1.0 - initial release
// ============================================================================
module gmsk_rx #(
    parameter int SAMPLE_BITS        = 8,
    parameter int SAMPLES_PER_SYMBOL = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sample_strobe,
    input  logic                          symbol_strobe,
    input  logic signed [SAMPLE_BITS-1:0] inphase_in,
    input  logic signed [SAMPLE_BITS-1:0] quadrature_in,
    output logic                          output_bit,
    output logic                          bit_valid
);

    localparam int C_LOG2_D      = $clog2(SAMPLES_PER_SYMBOL);
    localparam int ACC_BITS      = 2*SAMPLE_BITS + 1 + C_LOG2_D + 1;
    localparam int C_PROD_BITS   = 2*SAMPLE_BITS;
    localparam int C_METRIC_BITS = C_PROD_BITS + 1;
    localparam int C_FILL_BITS   = $clog2(SAMPLES_PER_SYMBOL + 1);
    localparam logic [C_FILL_BITS-1:0] C_FILL_FULL = C_FILL_BITS'(SAMPLES_PER_SYMBOL);

    // ------------------------------------------------------------------
    // Delay line and fill counter
    // ------------------------------------------------------------------
    logic signed [SAMPLE_BITS-1:0] r_i_line [SAMPLES_PER_SYMBOL];
    logic signed [SAMPLE_BITS-1:0] r_q_line [SAMPLES_PER_SYMBOL];
    logic [C_FILL_BITS-1:0]        r_fill;
    logic                          w_full;

    assign w_full = (r_fill == C_FILL_FULL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SAMPLES_PER_SYMBOL; k++) begin
                r_i_line[k] <= '0;
                r_q_line[k] <= '0;
            end
            r_fill <= '0;
        end else if (sample_strobe) begin
            r_i_line[0] <= inphase_in;
            r_q_line[0] <= quadrature_in;
            for (int k = 1; k < SAMPLES_PER_SYMBOL; k++) begin
                r_i_line[k] <= r_i_line[k-1];
                r_q_line[k] <= r_q_line[k-1];
            end
            if (!w_full) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage A: capture current sample and the one D strobes earlier
    // ------------------------------------------------------------------
    logic signed [SAMPLE_BITS-1:0] r_i0;
    logic signed [SAMPLE_BITS-1:0] r_q0;
    logic signed [SAMPLE_BITS-1:0] r_id;
    logic signed [SAMPLE_BITS-1:0] r_qd;
    logic                          r_a_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_i0      <= '0;
            r_q0      <= '0;
            r_id      <= '0;
            r_qd      <= '0;
            r_a_valid <= 1'b0;
        end else begin
            // Fullness is judged before this sample's own increment.
            r_a_valid <= sample_strobe && w_full;
            if (sample_strobe) begin
                r_i0 <= inphase_in;
                r_q0 <= quadrature_in;
                r_id <= r_i_line[SAMPLES_PER_SYMBOL-1];
                r_qd <= r_q_line[SAMPLES_PER_SYMBOL-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: cross-product metric, positive for counter-clockwise turn
    // ------------------------------------------------------------------
    logic signed [C_PROD_BITS-1:0]   w_prod_qi;
    logic signed [C_PROD_BITS-1:0]   w_prod_iq;
    logic signed [C_METRIC_BITS-1:0] w_metric;
    logic signed [C_METRIC_BITS-1:0] r_metric;
    logic                            r_b_valid;

    always_comb begin
        w_prod_qi = C_PROD_BITS'(r_q0) * C_PROD_BITS'(r_id);
        w_prod_iq = C_PROD_BITS'(r_i0) * C_PROD_BITS'(r_qd);
        w_metric  = {w_prod_qi[C_PROD_BITS-1], w_prod_qi}
                  - {w_prod_iq[C_PROD_BITS-1], w_prod_iq};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_metric  <= '0;
            r_b_valid <= 1'b0;
        end else begin
            r_metric  <= w_metric;
            r_b_valid <= r_a_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stage C: integrate over the symbol and slice on the boundary
    // ------------------------------------------------------------------
    logic signed [ACC_BITS-1:0] r_acc;
    logic                       r_acc_used;
    logic signed [ACC_BITS-1:0] w_metric_ext;
    logic                       w_acc_positive;

    assign w_metric_ext   = {{(ACC_BITS-C_METRIC_BITS){r_metric[C_METRIC_BITS-1]}}, r_metric};
    assign w_acc_positive = !r_acc[ACC_BITS-1] && (r_acc != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_acc_used <= 1'b0;
            output_bit <= 1'b0;
            bit_valid  <= 1'b0;
        end else if (symbol_strobe) begin
            output_bit <= w_acc_positive;
            bit_valid  <= r_acc_used;
            // A metric landing on the boundary opens the new symbol.
            r_acc      <= r_b_valid ? w_metric_ext : '0;
            r_acc_used <= r_b_valid;
        end else begin
            bit_valid <= 1'b0;
            if (r_b_valid) begin
                r_acc      <= r_acc + w_metric_ext;
                r_acc_used <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmsk_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmsk_rx
// Brief    : Self-checking bench for gmsk_rx against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gmsk_rx;

    localparam int SB = 8;
    localparam int D  = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 sample_strobe;
    logic                 symbol_strobe;
    logic signed [SB-1:0] inphase_in;
    logic signed [SB-1:0] quadrature_in;
    logic                 output_bit;
    logic                 bit_valid;

    int checks   = 0;
    int failures = 0;

    gmsk_rx #(
        .SAMPLE_BITS        (SB),
        .SAMPLES_PER_SYMBOL (D)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .symbol_strobe (symbol_strobe),
        .inphase_in    (inphase_in),
        .quadrature_in (quadrature_in),
        .output_bit    (output_bit),
        .bit_valid     (bit_valid)
    );

    always #5 clock = ~clock;

    // Reference model: recent-sample history, metrics in flight with due cycle
    int     hist_i[$];
    int     hist_q[$];
    int     pend_val[$];
    longint pend_due[$];
    longint acc;
    bit     used;
    bit     exp_bit;
    bit     exp_valid;
    longint cyc = 0;
    int     ph  = 0;
    int     cos_tab[16] = '{100, 92, 71, 38, 0, -38, -71, -92,
                            -100, -92, -71, -38, 0, 38, 71, 92};

    function automatic void model_reset();
        hist_i.delete();
        hist_q.delete();
        pend_val.delete();
        pend_due.delete();
        acc       = 0;
        used      = 1'b0;
        exp_bit   = 1'b0;
        exp_valid = 1'b0;
    endfunction

    task automatic model_clock(input bit ss, input bit sym, input int iv, input int qv);
        bit bv;
        int m;
        bv = 1'b0;
        m  = 0;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            bv = 1'b1;
            m  = pend_val.pop_front();
            void'(pend_due.pop_front());
        end
        if (sym) begin
            exp_bit   = (acc > 0);
            exp_valid = used;
            acc       = bv ? m : 0;
            used      = bv;
        end else begin
            exp_valid = 1'b0;
            if (bv) begin
                acc  += m;
                used = 1'b1;
            end
        end
        if (ss) begin
            if (hist_i.size() == D) begin
                pend_val.push_back(qv * hist_i[0] - iv * hist_q[0]);
                pend_due.push_back(cyc + 2);
                void'(hist_i.pop_front());
                void'(hist_q.pop_front());
            end
            hist_i.push_back(iv);
            hist_q.push_back(qv);
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input bit ss, input bit sym, input int iv, input int qv);
        sample_strobe = ss;
        symbol_strobe = sym;
        inphase_in    = 8'(iv);
        quadrature_in = 8'(qv);
        @(posedge clock);
        model_clock(ss, sym, iv, qv);
        #1;
        chk("bit_valid", bit_valid, exp_valid);
        chk("output_bit", output_bit, exp_bit);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, rnd_sample(), rnd_sample());
    endtask

    // Phasor advancing dir*22.5 degrees per sample, symbol strobe with each group's first sample
    task automatic rotate(input int dir, input int nsym);
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < D; k++) begin
                step(1'b1, k == 0, cos_tab[ph], cos_tab[(ph + 12) % 16]);
                ph = (ph + dir + 16) % 16;
            end
        end
    endtask

    initial begin
        int cnt;
        reset         = 1'b1;
        sample_strobe = 1'b0;
        symbol_strobe = 1'b0;
        inphase_in    = '0;
        quadrature_in = '0;
        model_reset();
        #1;
        chk("reset_bit_valid", bit_valid, 1'b0);
        chk("reset_output_bit", output_bit, 1'b0);
        idle(3);
        reset = 1'b0;

        // Warm-up: a boundary before the line fills yields no decision
        for (int k = 0; k < D - 1; k++) step(1'b1, 1'b0, rnd_sample(), rnd_sample());
        idle(1);
        step(1'b0, 1'b1, 0, 0);
        chk("warmup_no_valid", bit_valid, 1'b0);

        // Counter-clockwise rotation
        rotate(1, 10);
        idle(2);
        step(1'b0, 1'b1, 0, 0);
        chk("pos_rotation_valid", bit_valid, 1'b1);
        chk("pos_rotation_bit", output_bit, 1'b1);

        // Asynchronous reset between clock edges with a live accumulator
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", bit_valid, 1'b0);
        chk("async_reset_bit", output_bit, 1'b0);
        model_reset();
        idle(2);
        reset = 1'b0;

        // Clockwise rotation, including warm-up after the reset
        rotate(-1, 11);
        idle(2);
        step(1'b0, 1'b1, 0, 0);
        chk("neg_rotation_valid", bit_valid, 1'b1);
        chk("neg_rotation_bit", output_bit, 1'b0);

        // Boundary coinciding with a +5000 metric
        for (int k = 0; k < D; k++) step(1'b1, 1'b0, 100, 0);
        step(1'b1, 1'b0, 0, 50);
        idle(1);
        step(1'b0, 1'b1, 0, 0);
        idle(3);
        step(1'b0, 1'b1, 0, 0);
        chk("simul_new_valid", bit_valid, 1'b1);
        chk("simul_new_bit", output_bit, 1'b1);

        // All-zero input
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < D; k++) step(1'b1, k == 0, 0, 0);
        end
        idle(2);
        step(1'b0, 1'b1, 0, 0);
        chk("zero_valid", bit_valid, 1'b1);
        chk("zero_bit", output_bit, 1'b0);

        // Random strobes and full-range samples, at most D+2 samples per symbol
        cnt = 0;
        for (int n = 0; n < 800; n++) begin
            bit ss;
            bit sym;
            ss  = ($urandom_range(0, 3) != 0);
            sym = (cnt >= D + 2) || (cnt >= D - 1 && $urandom_range(0, 2) == 0);
            cnt = sym ? int'(ss) : cnt + int'(ss);
            if (n == 400) reset = 1'b1;
            if (n == 402) reset = 1'b0;
            step(ss, sym, rnd_sample(), rnd_sample());
        end

        // MSK-like phase walk driven by random bits
        for (int b = 0; b < 150; b++) begin
            rotate(($urandom_range(0, 1) != 0) ? 1 : -1, 1);
        end
        idle(2);
        step(1'b0, 1'b1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
